// File: rtl/shot_timer_pkg.sv
// Shared types for the shot-clock controller: FSM state encoding, the BCD digit pair,
// and a BCD decrement helper.
// No logic, so no latency or backpressure; the package holds only types, constants and a pure function.
package shot_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RUN      = 3'd2,
        ST_PAUSE    = 3'd3,
        ST_EXT_LOAD = 3'd4,
        ST_EXPIRED  = 3'd5
    } state_t;

    // Two BCD digits, tens in the upper nibble.
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd2_t;

    localparam bcd2_t BCD_ZERO = 8'h00;
    localparam bcd2_t BCD_MAX  = 8'h99;

    // BCD decrement: x0 borrows from the tens digit and becomes (x-1)9.
    function automatic bcd2_t bcd_dec(input bcd2_t v);
        bcd2_t r;
        if (v.units == 4'd0) begin
            r.tens  = v.tens - 4'd1;
            r.units = 4'd9;
        end else begin
            r.tens  = v.tens;
            r.units = v.units - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shot_timer_ctrl_if.sv
// Groups the shot-clock event inputs and the status outputs into a single bus.
// Inputs: one_sec, turn_start, shot_taken, pause, extend_req. Outputs: timeL, timeH, running, warning, timeout, ext_used.
// There is no flow control. The master drives the events, and the slave (the controller) drives the status signals.
interface shot_timer_ctrl_if;
    logic       one_sec;
    logic       turn_start;
    logic       shot_taken;
    logic       pause;
    logic       extend_req;
    logic [3:0] timeL;
    logic [3:0] timeH;
    logic       running;
    logic       warning;
    logic       timeout;
    logic       ext_used;

    modport master (
        output one_sec, turn_start, shot_taken, pause, extend_req,
        input  timeL, timeH, running, warning, timeout, ext_used
    );

    modport slave (
        input  one_sec, turn_start, shot_taken, pause, extend_req,
        output timeL, timeH, running, warning, timeout, ext_used
    );
endinterface

// File: rtl/shot_timer_ctrl_bcddn.sv
// Two-digit BCD down counter with synchronous load; the count stops at 00 instead of wrapping.
// Ports: clk, resetN (async, active-low), loadN, enable1, enable2, din_i, cnt_o, tc (count == 00).
// Loads or decrements on the clock edge, and the new value is visible in the next cycle. No backpressure.
module bcddn
    import shot_timer_pkg::*;
(
    input  logic  clk,
    input  logic  resetN,
    input  logic  loadN,
    input  logic  enable1,
    input  logic  enable2,
    input  bcd2_t din_i,
    output bcd2_t cnt_o,
    output logic  tc
);

    bcd2_t cnt_q, cnt_d;

    assign tc    = (cnt_q == BCD_ZERO);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!loadN) begin
            cnt_d = din_i;
        end else if (enable1 && enable2 && !tc) begin
            cnt_d = bcd_dec(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= BCD_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shot_timer_ctrl.sv
// Pool shot-clock controller: a BCD countdown with pause, a single extension per turn, a low-time warning and an expiry pulse.
// Ports: clk, resetN (async, active-low), and bus (the shot_timer_ctrl_if slave modport) carrying the events and status outputs.
// Events act on the clock edge. LOAD and EXT_LOAD each take one cycle. There is no backpressure, and a lower-priority event in the same cycle is dropped.
module shot_timer_ctrl
    import shot_timer_pkg::*;
#(
    parameter logic [7:0] SHOT_TIME = 8'h30,
    parameter logic [7:0] EXT_TIME  = 8'h15,
    parameter logic [7:0] WARN_TIME = 8'h05
)
(
    input  logic              clk,
    input  logic              resetN,
    shot_timer_ctrl_if.slave  bus
);

    state_t state_q, state_d;
    state_t ret_q, ret_d;          // state to return to after EXT_LOAD
    logic   ext_used_q, ext_used_d;
    logic   timeout_q, timeout_d;

    logic   load;
    logic   dec_ok;
    bcd2_t  load_val;
    bcd2_t  cnt;
    logic   tc;
    bcd2_t  ext_sum;

    // Saturating BCD adder: current time + EXT_TIME, clamped to 99.
    logic [4:0] u_raw, u_adj;
    logic       u_carry;
    logic [4:0] t_raw;

    always_comb begin
        u_raw   = {1'b0, cnt.units} + {1'b0, EXT_TIME[3:0]};
        u_carry = (u_raw > 5'd9);
        u_adj   = u_carry ? (u_raw - 5'd10) : u_raw;
        t_raw   = {1'b0, cnt.tens} + {1'b0, EXT_TIME[7:4]} + {4'd0, u_carry};
        if (t_raw > 5'd9) begin
            ext_sum = BCD_MAX;
        end else begin
            ext_sum.tens  = t_raw[3:0];
            ext_sum.units = u_adj[3:0];
        end
    end

    // Next-state logic. Within each state, the branch order gives the event priority.
    // Expiry is checked ahead of extend_req, so an extension requested in the expiry cycle is lost.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        ext_used_d = ext_used_q;
        timeout_d  = 1'b0;
        load       = 1'b0;
        load_val   = bcd2_t'(SHOT_TIME);
        dec_ok     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.turn_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                load       = 1'b1;
                ext_used_d = 1'b0;
                if (bus.turn_start)  state_d = ST_LOAD;
                else if (bus.pause)  state_d = ST_PAUSE;
                else                 state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.turn_start) begin
                    state_d = ST_LOAD;
                end else if (bus.shot_taken) begin
                    state_d = ST_IDLE;
                end else if (tc) begin
                    state_d   = ST_EXPIRED;
                    timeout_d = 1'b1;
                end else if (bus.extend_req && !ext_used_q) begin
                    state_d = ST_EXT_LOAD;
                    ret_d   = ST_RUN;
                end else if (bus.pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    dec_ok = bus.one_sec;
                end
            end
            ST_PAUSE: begin
                if (bus.turn_start) begin
                    state_d = ST_LOAD;
                end else if (bus.shot_taken) begin
                    state_d = ST_IDLE;
                end else if (bus.extend_req && !ext_used_q) begin
                    state_d = ST_EXT_LOAD;
                    ret_d   = ST_PAUSE;
                end else if (!bus.pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_EXT_LOAD: begin
                // The counter is frozen outside RUN, so ext_sum still reflects the time at request.
                if (bus.turn_start) begin
                    state_d = ST_LOAD;
                end else if (bus.shot_taken) begin
                    state_d = ST_IDLE;
                end else begin
                    load       = 1'b1;
                    load_val   = ext_sum;
                    ext_used_d = 1'b1;
                    state_d    = ret_q;
                end
            end
            ST_EXPIRED: begin
                if (bus.turn_start) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            ret_q      <= ST_RUN;
            ext_used_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            ext_used_q <= ext_used_d;
            timeout_q  <= timeout_d;
        end
    end

    // enable2 carries one_sec only when no higher-priority event claims the cycle,
    // so a strobe that coincides with such an event is dropped.
    bcddn u_cnt (
        .clk     (clk),
        .resetN  (resetN),
        .loadN   (~load),
        .enable1 (state_q == ST_RUN),
        .enable2 (dec_ok),
        .din_i   (load_val),
        .cnt_o   (cnt),
        .tc      (tc)
    );

    assign bus.timeL    = cnt.units;
    assign bus.timeH    = cnt.tens;
    assign bus.running  = (state_q == ST_RUN);
    assign bus.warning  = ((state_q == ST_RUN) || (state_q == ST_PAUSE))
                          && (cnt <= WARN_TIME) && !tc;
    assign bus.timeout  = timeout_q;
    assign bus.ext_used = ext_used_q;

endmodule

// File: doc/shot_timer_ctrl.md
SHOT_TIMER_CTRL -- requirements
Module: shot_timer_ctrl

Interface
REQ-001 Parameter SHOT_TIME, default 8'h30, BCD {tens,units} shot-clock start value in seconds.
REQ-002 Parameter EXT_TIME, default 8'h15, BCD seconds added by one extension.
REQ-003 Parameter WARN_TIME, default 8'h05, BCD threshold; warning is asserted at or below it.
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 resetN  in  1  asynchronous, active-low reset.
REQ-006 one_sec  in  1  single-cycle 1 Hz strobe.
REQ-007 turn_start  in  1  single-cycle pulse; a new shot turn begins.
REQ-008 shot_taken  in  1  single-cycle pulse; the player struck the cue ball.
REQ-009 pause  in  1  level; freezes countdown while high.
REQ-010 extend_req  in  1  single-cycle pulse; requests one extension per turn.
REQ-011 timeL  out  4  BCD units of remaining time.
REQ-012 timeH  out  4  BCD tens of remaining time.
REQ-013 running  out  1  high in RUN only.
REQ-014 warning  out  1  high in RUN/PAUSE when time <= WARN_TIME and time != 00.
REQ-015 timeout  out  1  single-cycle pulse on expiry.
REQ-016 ext_used  out  1  high once the turn's extension is consumed.

Function
REQ-017 States: IDLE, LOAD, RUN, PAUSE, EXT_LOAD, EXPIRED.
REQ-018 Event priority, highest first: turn_start, shot_taken, extend_req, pause, one_sec.
REQ-019 turn_start, in any state, goes to LOAD; LOAD lasts exactly 1 cycle, loads SHOT_TIME, clears ext_used, then enters RUN (pause low) or PAUSE (pause high).
REQ-020 In RUN, one_sec decrements time by 1 in BCD (x0 -> (x-1)9) in the same edge; count visible the next cycle.
REQ-021 In RUN, time == 00 moves to EXPIRED and pulses timeout for exactly 1 cycle; no decrement below 00 (no wrap to 99).
REQ-022 RUN with pause high -> PAUSE; PAUSE with pause low -> RUN; one_sec ignored in PAUSE.
REQ-023 shot_taken in RUN/PAUSE/EXT_LOAD -> IDLE; time holds its value; ignored in IDLE/EXPIRED.
REQ-024 extend_req in RUN/PAUSE with ext_used low: compute time + EXT_TIME in BCD, saturate at 99, enter EXT_LOAD for 1 cycle to load the sum, set ext_used, return to the originating state.
REQ-025 extend_req with ext_used high, or in IDLE/LOAD/EXPIRED, is ignored.
REQ-026 one_sec coinciding with LOAD, EXT_LOAD or a load-causing event is dropped.
REQ-027 EXPIRED holds time at 00 until turn_start; extend_req in the expiry cycle is ignored.

Reset
REQ-028 resetN low asynchronously forces IDLE, time 00, and running, warning, timeout, ext_used all 0, including mid-count or mid-load.
REQ-029 The first turn_start after reset release behaves per REQ-019.

Structure
REQ-030 State enum and BCD-pair typedef shall live in a shared package shot_timer_pkg.
REQ-031 The counter shall be one instance of bcddn (loadN = ~load, enable1 = state==RUN, enable2 = one_sec, tc used for expiry).
REQ-032 The BCD saturating adder shall be combinational logic inside shot_timer_ctrl.

Verification
REQ-033 Reset, turn_start, 30 one_sec strobes -> time 30..00, timeout single pulse after reaching 00, EXPIRED, time stays 00.
REQ-034 At time 07, extend_req -> time 22 two cycles later, ext_used=1; second extend_req -> no change.
REQ-035 At time 90 (SHOT_TIME=8'h90), extend_req -> time saturates at 99.
REQ-036 pause high for 5 strobes at time 12 -> time stays 12; release -> decrements resume; warning rises at 05, low at 00.
REQ-037 shot_taken together with one_sec at 10 -> IDLE, time 10; turn_start together with shot_taken -> LOAD wins, time 30.
REQ-038 resetN low mid-RUN at 17 -> immediately IDLE, time 00, all outputs 0.
